// File: rtl/rv_pc_pkg.sv
// Shared types and widths for the next-PC generation stage.
package rv_pc_pkg;

    localparam int PC_W       = 32;
    localparam int INSN_BYTES = 4;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALT   = 2'd2
    } pc_state_e;

endpackage

// File: rtl/next_pc_target.sv
// Redirect target computation for branch/JAL/JALR plus the alignment check.
module next_pc_target
    import rv_pc_pkg::*;
(
    input  logic            is_jalr,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [PC_W-1:0] imm,
    input  logic [PC_W-1:0] rs1,
    output logic [PC_W-1:0] target,
    output logic            misaligned
);

    logic [PC_W-1:0] relTarget;
    logic [PC_W-1:0] regTarget;

    always_comb begin
        relTarget = ex_pc + imm;
        regTarget = (rs1 + imm) & ~{{(PC_W-1){1'b0}}, 1'b1};
        target    = is_jalr ? regTarget : relTarget;
        // JALR clears bit 0 itself, so only bit 1 can misalign it
        misaligned = is_jalr ? regTarget[1] : (relTarget[1] | relTarget[0]);
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC generator: sequential advance, EX-stage redirects with flush, misalignment trap.
module next_pc_unit
    import rv_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        BrE,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [31:0] ex_pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        stall,
    input  logic        if_ready,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        misalign,
    output logic [31:0] bad_target,
    output logic [15:0] redirect_count
);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] badTarget_q, badTarget_d;
    logic [CNT_W-1:0] redirectCount_q, redirectCount_d;
    logic            pcValid_q, pcValid_d;

    logic            taken;
    logic [PC_W-1:0] target;
    logic            targetMisaligned;

    assign taken = (is_branch & BrE) | is_jal | is_jalr;

    next_pc_target u_target (
        .is_jalr    (is_jalr),
        .ex_pc      (ex_pc),
        .imm        (imm),
        .rs1        (rs1),
        .target     (target),
        .misaligned (targetMisaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= RUN;
            pc_q            <= RESET_PC;
            badTarget_q     <= '0;
            redirectCount_q <= '0;
            pcValid_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            badTarget_q     <= badTarget_d;
            redirectCount_q <= redirectCount_d;
            pcValid_q       <= pcValid_d;
        end
    end

    // A redirect beats stall and if_ready; advance only once a request is actually valid
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        badTarget_d     = badTarget_q;
        redirectCount_d = redirectCount_q;
        case (state_q)
            RUN: begin
                if (taken && targetMisaligned) begin
                    state_d     = HALT;
                    badTarget_d = target;
                end else if (taken) begin
                    state_d = BUBBLE;
                    pc_d    = target;
                    if (redirectCount_q != '1) begin
                        redirectCount_d = redirectCount_q + CNT_W'(1);
                    end
                end else if (pcValid_q && if_ready && !stall) begin
                    pc_d = pc_q + PC_W'(INSN_BYTES);
                end
            end
            BUBBLE:  state_d = RUN;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
        pcValid_d = (state_d == RUN);
    end

    always_comb begin
        flush    = 1'b0;
        misalign = 1'b0;
        if (rst_n && state_q == RUN && taken) begin
            flush    = 1'b1;
            misalign = targetMisaligned;
        end
    end

    assign pc             = pc_q;
    assign pc_valid       = pcValid_q;
    assign bad_target     = badTarget_q;
    assign redirect_count = redirectCount_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit with hand-computed expectations.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        BrE, is_branch, is_jal, is_jalr;
    logic [31:0] ex_pc, imm, rs1;
    logic        stall, if_ready;
    logic [31:0] pc;
    logic        pc_valid, flush, misalign;
    logic [31:0] bad_target;
    logic [15:0] redirect_count;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    next_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .BrE            (BrE),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .ex_pc          (ex_pc),
        .imm            (imm),
        .rs1            (rs1),
        .stall          (stall),
        .if_ready       (if_ready),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .flush          (flush),
        .misalign       (misalign),
        .bad_target     (bad_target),
        .redirect_count (redirect_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic br, input logic bre, input logic jal, input logic jalr,
                                 input logic [31:0] exPc, input logic [31:0] immV, input logic [31:0] rs1V,
                                 input logic stl, input logic rdy);
        is_branch = br;
        BrE       = bre;
        is_jal    = jal;
        is_jalr   = jalr;
        ex_pc     = exPc;
        imm       = immV;
        rs1       = rs1V;
        stall     = stl;
        if_ready  = rdy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        tick();
        tick();
        checkOutput("rst_flush", {31'b0, flush}, 32'h0);
        checkOutput("rst_misalign", {31'b0, misalign}, 32'h0);
        checkOutput("rst_pc_valid", {31'b0, pc_valid}, 32'h0);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_count", {16'b0, redirect_count}, 32'h0);
        checkOutput("rst_bad", bad_target, 32'h0);

        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_valid", {31'b0, pc_valid}, 32'h1);
        checkOutput("post_rst_pc", pc, 32'h0);

        // Sequential advance: ready 1,0,1,1 with stall on the last cycle
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
        tick();
        checkOutput("seq_pc1", pc, 32'h4);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        tick();
        checkOutput("seq_pc2", pc, 32'h4);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
        tick();
        checkOutput("seq_pc3", pc, 32'h8);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 1);
        tick();
        checkOutput("seq_pc4", pc, 32'h8);

        // Taken branch
        applyStimulus(1, 1, 0, 0, 32'h100, 32'h20, 32'h0, 0, 0);
        checkOutput("br_flush", {31'b0, flush}, 32'h1);
        checkOutput("br_misalign", {31'b0, misalign}, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        checkOutput("br_pc", pc, 32'h120);
        checkOutput("br_bubble_valid", {31'b0, pc_valid}, 32'h0);
        checkOutput("br_bubble_flush", {31'b0, flush}, 32'h0);
        checkOutput("br_count", {16'b0, redirect_count}, 32'h1);
        tick();
        checkOutput("br_valid", {31'b0, pc_valid}, 32'h1);
        checkOutput("br_pc_held", pc, 32'h120);

        // Not-taken branch
        applyStimulus(1, 0, 0, 0, 32'h100, 32'h20, 32'h0, 0, 0);
        checkOutput("nt_flush", {31'b0, flush}, 32'h0);
        tick();
        checkOutput("nt_pc", pc, 32'h120);
        checkOutput("nt_count", {16'b0, redirect_count}, 32'h1);

        // JALR with bit 0 masked off, then a taken JALR during the bubble
        applyStimulus(0, 0, 0, 1, 32'h0, 32'h3, 32'h2001, 0, 1);
        checkOutput("jalr_flush", {31'b0, flush}, 32'h1);
        tick();
        checkOutput("jalr_pc", pc, 32'h2004);
        checkOutput("jalr_count", {16'b0, redirect_count}, 32'h2);
        applyStimulus(0, 0, 0, 1, 32'h0, 32'h0, 32'h3000, 0, 1);
        checkOutput("bubble_flush", {31'b0, flush}, 32'h0);
        tick();
        checkOutput("bubble_pc", pc, 32'h2004);
        checkOutput("bubble_count", {16'b0, redirect_count}, 32'h2);
        checkOutput("bubble_exit_valid", {31'b0, pc_valid}, 32'h1);

        // JAL with stall asserted, target wraps past 2^32
        applyStimulus(0, 0, 1, 0, 32'hFFFF_FFF0, 32'h20, 32'h0, 1, 0);
        checkOutput("wrap_flush", {31'b0, flush}, 32'h1);
        tick();
        checkOutput("wrap_pc", pc, 32'h10);
        checkOutput("wrap_count", {16'b0, redirect_count}, 32'h3);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        tick();

        // Misaligned JALR: trap and halt
        applyStimulus(0, 0, 0, 1, 32'h0, 32'h0, 32'h1003, 0, 1);
        checkOutput("mis_pulse", {31'b0, misalign}, 32'h1);
        checkOutput("mis_flush", {31'b0, flush}, 32'h1);
        tick();
        checkOutput("mis_pulse_end", {31'b0, misalign}, 32'h0);
        checkOutput("mis_halt_flush", {31'b0, flush}, 32'h0);
        checkOutput("mis_bad", bad_target, 32'h1002);
        checkOutput("mis_valid", {31'b0, pc_valid}, 32'h0);
        checkOutput("mis_pc", pc, 32'h10);
        checkOutput("mis_count", {16'b0, redirect_count}, 32'h3);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
        tick();
        checkOutput("halt_valid", {31'b0, pc_valid}, 32'h0);
        checkOutput("halt_pc", pc, 32'h10);

        // Reset out of HALT
        rst_n = 1'b0;
        tick();
        checkOutput("halt_rst_pc", pc, 32'h0);
        checkOutput("halt_rst_bad", bad_target, 32'h0);
        checkOutput("halt_rst_count", {16'b0, redirect_count}, 32'h0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        tick();
        checkOutput("halt_rst_valid", {31'b0, pc_valid}, 32'h1);

        // Saturation of the redirect counter
        force dut.redirectCount_q = 16'hFFFF;
        #1;
        release dut.redirectCount_q;
        #1;
        checkOutput("sat_preload", {16'b0, redirect_count}, 32'hFFFF);
        applyStimulus(0, 0, 1, 0, 32'h40, 32'h10, 32'h0, 0, 0);
        tick();
        checkOutput("sat_count", {16'b0, redirect_count}, 32'hFFFF);
        checkOutput("sat_pc", pc, 32'h50);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        tick();

        // Branch target with bit 0 set is misaligned
        applyStimulus(1, 1, 0, 0, 32'h200, 32'h1, 32'h0, 0, 0);
        checkOutput("br_mis_pulse", {31'b0, misalign}, 32'h1);
        tick();
        checkOutput("br_mis_bad", bad_target, 32'h201);
        checkOutput("br_mis_pc", pc, 32'h50);
        checkOutput("br_mis_valid", {31'b0, pc_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Program-counter generation stage that consumes the EX-stage branch-compare result (`BrE`) and jump decode, and produces the fetch address for the instruction-fetch stage. It holds the architectural fetch PC and advances it sequentially under a valid/ready handshake with fetch. On a taken branch or jump it redirects to the computed target and flushes wrong-path instructions. It traps on a misaligned target, halting fetch until reset, and keeps a saturating redirect counter for performance monitoring.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `BrE`  in  1  branch condition result for the instruction in EX.
- `is_branch`  in  1  EX holds a conditional branch.
- `is_jal`  in  1  EX holds JAL.
- `is_jalr`  in  1  EX holds JALR.
- `ex_pc`  in  32  PC of the EX instruction.
- `imm`  in  32  sign-extended immediate of the EX instruction.
- `rs1`  in  32  rs1 operand for JALR.
- `stall`  in  1  hazard-unit stall; suppresses sequential advance.
- `if_ready`  in  1  fetch accepts `pc` this cycle.
- `pc`  out  32  fetch address.
- `pc_valid`  out  1  `pc` is a valid fetch request.
- `flush`  out  1  kill IF/ID and ID/EX contents this cycle.
- `misalign`  out  1  one-cycle trap pulse on a misaligned target.
- `bad_target`  out  32  latched misaligned target.
- `redirect_count`  out  16  saturating count of redirects.

## Operation
- `taken` = (`is_branch` & `BrE`) | `is_jal` | `is_jalr`.
- Branch and JAL target = `ex_pc` + `imm`.
- JALR target = (`rs1` + `imm`) & ~32'h1.
- All additions wrap modulo 2^32.
- A target is misaligned when `target[1]` = 1. Bit 0 is always 0 after masking for JALR. For branch and JAL, either `target[1]` or `target[0]` set counts as misaligned.
- States: RUN, BUBBLE, HALT.
- RUN:
  - `pc_valid` = 1.
  - Precedence: misaligned taken, then valid taken, then advance, then hold.
  - Misaligned taken: `misalign` = 1 and `flush` = 1 this cycle. `bad_target` latches the target. Go to HALT; `pc` holds.
  - Valid taken: `flush` = 1 this cycle (combinational). `pc` loads the target at the edge and the state goes to BUBBLE. `redirect_count` increments, saturating at 16'hFFFF. The redirect overrides `stall` and `if_ready`.
  - Advance: `if_ready` & !`stall` gives `pc` <= `pc` + 4, wrapping.
  - Otherwise `pc` holds.
- BUBBLE:
  - `pc_valid` = 0 and `flush` = 0.
  - `taken` is ignored, because EX holds a wrong-path or flushed instruction.
  - Return to RUN unconditionally after one cycle.
- HALT:
  - `pc_valid` = 0 and `flush` = 0.
  - All inputs are ignored; only reset exits.
- Handshake:
  - While `pc_valid` & !`if_ready` & !`flush`, `pc` stays stable.
  - An unaccepted request may be withdrawn only in a cycle with `flush` = 1.
- Reset (`rst_n` = 0 at an edge):
  - `pc` = `RESET_PC`, state = RUN, `redirect_count` = 0, `bad_target` = 0.
  - During reset, `flush` = 0, `misalign` = 0 and `pc_valid` = 0.
  - Reset mid-BUBBLE or mid-HALT behaves identically.

## Timing
- Redirect latency: `taken` in cycle N gives `flush` in cycle N, the target on `pc` with `pc_valid` = 0 in cycle N+1, and `pc_valid` = 1 with the target in cycle N+2.
- Sequential advance takes effect one cycle after the accepting edge.
- `misalign` is high for exactly one cycle. `bad_target` is valid from the following cycle and is held until reset.
- `flush` and `misalign` are combinational from the EX inputs, qualified by state == RUN and `rst_n`. All other outputs are registered.
- Simultaneous `taken` and `stall`: the redirect wins. Simultaneous `taken` and `if_ready`: the redirect wins and the accepted `pc` is treated as wrong-path.

## Structure
- Shared package `rv_pc_pkg`:
  - state enum (RUN, BUBBLE, HALT)
  - `PC_W` = 32
  - `INSN_BYTES` = 4
  - `CNT_W` = 16
- One natural sub-module, `next_pc_target`: a combinational target adder, JALR mask, and misalignment check.
- Everything else lives in `next_pc_unit`.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles, then release. Required: `pc` = 0x0; `pc_valid` = 0 during reset and 1 after; `flush` = 0; `misalign` = 0; `redirect_count` = 0.
- Sequential advance: toggle `if_ready` 1,0,1,1 with `stall` = 1 on the fourth cycle. Required: `pc` goes 0x0, 0x4, 0x4, 0x8, 0x8.
- Branch taken: `ex_pc` = 0x100, `imm` = 0x20, `is_branch` = 1, `BrE` = 1. Required: `flush` = 1 that cycle; next cycle `pc` = 0x120 with `pc_valid` = 0; then `pc_valid` = 1; `redirect_count` = 1. Repeat with `BrE` = 0: required `flush` = 0.
- JALR:
  - `rs1` = 0x2001, `imm` = 3: required redirect to 0x2004.
  - `rs1` = 0x1003, `imm` = 0: target is 0x1002. Required: `misalign` pulse, `bad_target` = 0x1002, `pc_valid` = 0 thereafter; then `rst_n` = 0 restores `pc` = 0x0.
- Taken during BUBBLE is ignored: `redirect_count` is unchanged and `pc` is unchanged. A redirect with `stall` = 1 still loads the target.
- Wrap-around: `ex_pc` = 0xFFFF_FFF0, `imm` = 0x20, `is_jal` = 1. Required: `pc` = 0x10. Separately, force `redirect_count` to 0xFFFF and issue a redirect: required it stays at 0xFFFF.
